reg_fifo: RTL and testbench
===========================

// Module: reg_fifo
// PURPOSE
//  Synchronous FIFO built from flop storage with valid/ready handshakes on both sides.
//  Sits directly upstream of the datapath registers and buffers words between a producer and the register stage.
//  The register stage loads a word when qout_valid && qout_ready.
//  Decouples producer stalls from consumer stalls without losing or duplicating words.
// PARAMETERS
//  WIDTH  20  data word width in bits
//  DEPTH  4   number of entries; power of two, >= 2
// PORTS
//  clk         in   1                    single clock, all state updates on posedge
//  rst_in      in   1                    reset, synchronous, active-high
//  din         in   WIDTH                write data
//  din_valid   in   1                    producer offers din this cycle
//  din_ready   out  1                    FIFO accepts din this cycle (= !full)
//  qout        out  WIDTH                head word; 0 when empty
//  qout_valid  out  1                    head word present (= !empty)
//  qout_ready  in   1                    consumer takes head this cycle
//  count       out  $clog2(DEPTH)+1      current occupancy, 0..DEPTH
//  full        out  1                    count == DEPTH
//  empty       out  1                    count == 0
// BEHAVIOUR
//  - Clocking and reset: one clock, clk. Reset rst_in is synchronous and active-high.
//  - Reset values:
//    - count=0, wr_ptr=0, rd_ptr=0.
//    - empty=1, full=0, din_ready=1, qout_valid=0, qout=0.
//    - Storage contents are not reset and are don't-care.
//  - push = din_valid && din_ready. pop = qout_valid && qout_ready. Both are evaluated in the same cycle.
//  - On push: mem[wr_ptr] <= din and wr_ptr <= wr_ptr+1. The pointer is log2(DEPTH) bits and wraps naturally.
//  - On pop: rd_ptr <= rd_ptr+1, same wrap.
//  - count update:
//    - push only: count+1.
//    - pop only: count-1.
//    - both, or neither: count unchanged.
//  - qout = empty ? 0 : mem[rd_ptr], driven combinationally from storage (first-word fall-through).
//  - Latency: a word pushed in cycle N is visible on qout/qout_valid in cycle N+1 when the FIFO was empty. No same-cycle bypass.
//  - Full: din_ready=0 and din is ignored. Pop in the same cycle frees a slot, but din_ready does not rise until the next cycle.
//  - Empty: qout_valid=0 and qout_ready is ignored. A push in the same cycle is accepted and pop is not.
//  - Push and pop together with 0<count<DEPTH: both happen. count is held and both pointers advance.
//  - Holding:
//    - din_valid held with din_ready low: no state change.
//    - Producer must keep din stable until accepted.
//    - qout is stable while qout_valid && !qout_ready.
//  - rst_in mid-operation:
//    - The next edge discards all words (count=0) and takes precedence over push/pop in that cycle.
//    - Outputs take reset values from the following cycle.
//  - Simulation only (`ifndef TARGET_SYNTHESIS):
//    - Area: add 17*WIDTH*DEPTH + 17*(2*log2(DEPTH)+log2(DEPTH)+1) to tbench_top.area at time 0 and $display it.
//    - Energy: add WIDTH*0.1 to tbench_top.energy on every push.
//  - Assertions (sim only):
//    - count never exceeds DEPTH.
//    - full and empty are never both high.
//    - din stable while din_valid && !din_ready.
// STRUCTURE
//  - Shared package fifo_pkg:
//    - localparam function ptr_w(depth) returning $clog2(depth).
//    - typedef fifo_op_e {OP_NONE, OP_PUSH, OP_POP, OP_BOTH} for control decode.
//  - Sub-module fifo_ptr_ctrl: owns wr_ptr, rd_ptr and count, generates full/empty/din_ready/qout_valid.
//    - Inputs: clk, rst_in, push, pop.
//  - reg_fifo: owns the storage array and qout mux, and instantiates fifo_ptr_ctrl.
// TESTING
//  1. Reset, then 4 pushes 0x00001..0x00004 with qout_ready=0.
//     -> count 1,2,3,4; full=1 and din_ready=0 after the 4th.
//     -> A 5th push of 0x00005 is ignored; qout=0x00001.
//  2. From test 1's full state, qout_ready=1 for 4 cycles.
//     -> qout 0x00001..0x00004 in order; then empty=1, qout=0, qout_valid=0.
//  3. count=2, din_valid=1 and qout_ready=1 for 10 cycles with incrementing data.
//     -> count stays 2; pointers wrap past 3 to 0; output order is preserved.
//  4. Empty FIFO, push 0xABCDE with qout_ready=1 in the same cycle.
//     -> No pop that cycle; next cycle qout=0xABCDE and qout_valid=1; popped that cycle.
//  5. count=3, assert rst_in together with push and pop.
//     -> Next cycle count=0, empty=1, qout=0, qout_valid=0; the pushed word is discarded.
//  6. Random valid/ready toggling, 1000 cycles, against a scoreboard queue.
//     -> Zero mismatches, no loss or duplication, assertions clean.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared sizing helper and control-decode type for reg_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Encoding matches {pop, push} so the decode is a plain cast.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage
`default_nettype wire

// File: rtl/fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ptr_ctrl
//  Description : Read/write pointers and occupancy for reg_fifo, plus flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = ptr_w(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_in,
    input  logic          push,
    input  logic          pop,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          din_ready,
    output logic          qout_valid
);

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    fifo_op_e      w_op;
    logic [PW-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [PW-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [CW-1:0] r_count_q,  w_count_d;
    logic          w_full;
    logic          w_empty;

    always_comb begin
        w_op       = fifo_op_e'({pop, push});
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        case (w_op)
            OP_PUSH: begin
                w_wr_ptr_d = r_wr_ptr_q + PW'(1);
                w_count_d  = r_count_q + CW'(1);
            end
            OP_POP: begin
                w_rd_ptr_d = r_rd_ptr_q + PW'(1);
                w_count_d  = r_count_q - CW'(1);
            end
            OP_BOTH: begin
                w_wr_ptr_d = r_wr_ptr_q + PW'(1);
                w_rd_ptr_d = r_rd_ptr_q + PW'(1);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // Flags come straight from the registered count, so a same-cycle pop
    // on a full FIFO cannot raise din_ready until the next cycle.
    assign w_full     = (r_count_q == C_DEPTH);
    assign w_empty    = (r_count_q == '0);
    assign wr_ptr     = r_wr_ptr_q;
    assign rd_ptr     = r_rd_ptr_q;
    assign count      = r_count_q;
    assign full       = w_full;
    assign empty      = w_empty;
    assign din_ready  = !w_full;
    assign qout_valid = !w_empty;

endmodule
`default_nettype wire

// File: rtl/reg_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : reg_fifo
//  Description : Flop-based first-word-fall-through FIFO with valid/ready ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_fifo
    import fifo_pkg::*;
#(
    parameter  int WIDTH = 20,
    parameter  int DEPTH = 4,
    localparam int PW    = ptr_w(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] qout,
    output logic             qout_valid,
    input  logic             qout_ready,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [WIDTH-1:0] w_mem_d [DEPTH];
    logic [PW-1:0]    w_wr_ptr;
    logic [PW-1:0]    w_rd_ptr;
    logic             w_push;
    logic             w_pop;
    logic             w_din_ready;
    logic             w_qout_valid;
    logic             w_empty;
    logic             w_full;
    logic [CW-1:0]    w_count;

    assign w_push = din_valid && w_din_ready;
    assign w_pop  = w_qout_valid && qout_ready;

    fifo_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk        (clk),
        .rst_in     (rst_in),
        .push       (w_push),
        .pop        (w_pop),
        .wr_ptr     (w_wr_ptr),
        .rd_ptr     (w_rd_ptr),
        .count      (w_count),
        .full       (w_full),
        .empty      (w_empty),
        .din_ready  (w_din_ready),
        .qout_valid (w_qout_valid)
    );

    always_comb begin
        w_mem_d = r_mem_q;
        if (w_push) begin
            w_mem_d[w_wr_ptr] = din;
        end
    end

    // Storage is deliberately left out of reset; the empty flag masks it.
    always_ff @(posedge clk) begin
        r_mem_q <= w_mem_d;
    end

    assign qout       = w_empty ? '0 : r_mem_q[w_rd_ptr];
    assign qout_valid = w_qout_valid;
    assign din_ready  = w_din_ready;
    assign count      = w_count;
    assign full       = w_full;
    assign empty      = w_empty;

`ifndef TARGET_SYNTHESIS
    logic             r_hold_q;
    logic [WIDTH-1:0] r_din_hold_q;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_hold_q     <= 1'b0;
            r_din_hold_q <= '0;
        end else begin
            r_hold_q     <= din_valid && !w_din_ready;
            r_din_hold_q <= din;
            assert (w_count <= C_DEPTH)
                else $error("reg_fifo: count %0d above depth", w_count);
            assert (!(w_full && w_empty))
                else $error("reg_fifo: full and empty together");
            if (r_hold_q) begin
                assert (din == r_din_hold_q)
                    else $error("reg_fifo: din changed while stalled");
            end
        end
    end

    // Area/energy bookkeeping needs a tbench_top with area and energy
    // variables, so it is only compiled when that bench defines the macro.
`ifdef REG_FIFO_TBENCH_ACCOUNTING
    initial begin
        tbench_top.area = tbench_top.area + 17*WIDTH*DEPTH + 17*(2*PW + PW + 1);
        $display("reg_fifo area %0d", tbench_top.area);
    end

    always @(posedge clk) begin
        if (!rst_in && w_push) begin
            tbench_top.energy = tbench_top.energy + WIDTH*0.1;
        end
    end
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_fifo
//  Description : Directed and scoreboard-driven checks for reg_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_fifo;

    localparam int WIDTH = 20;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_in;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] qout;
    logic             qout_valid;
    logic             qout_ready;
    logic [2:0]       count;
    logic             full;
    logic             empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .qout       (qout),
        .qout_valid (qout_valid),
        .qout_ready (qout_ready),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; din = '0; din_valid = 1'b0; qout_ready = 1'b0;
        step();
        step();
        rst_in = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready got %b exp 1", din_ready); end
        checks++; if (qout_valid !== 1'b0) begin errors++; $display("FAIL reset_qout_valid got %b exp 0", qout_valid); end
        checks++; if (qout !== 20'h0) begin errors++; $display("FAIL reset_qout got %h exp 00000", qout); end
    endtask

    task automatic test_fill();
        qout_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            din = 20'(i); din_valid = 1'b1;
            step();
            checks++; if (count !== 3'(i)) begin errors++; $display("FAIL fill_count got %0d exp %0d", count, i); end
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL fill_din_ready got %b exp 0", din_ready); end
        din = 20'h00005; din_valid = 1'b1;
        step();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_overflow_count got %0d exp 4", count); end
        checks++; if (qout !== 20'h00001) begin errors++; $display("FAIL fill_head got %h exp 00001", qout); end
    endtask

    task automatic test_drain();
        din_valid = 1'b0; qout_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (qout !== 20'(i)) begin errors++; $display("FAIL drain_qout got %h exp %h", qout, 20'(i)); end
            step();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
        checks++; if (qout !== 20'h0) begin errors++; $display("FAIL drain_qout_zero got %h exp 00000", qout); end
        checks++; if (qout_valid !== 1'b0) begin errors++; $display("FAIL drain_qout_valid got %b exp 0", qout_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", count); end
        qout_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        qout_ready = 1'b0;
        din = 20'h00010; din_valid = 1'b1; step();
        din = 20'h00011; din_valid = 1'b1; step();
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_prefill got %0d exp 2", count); end
        for (int i = 0; i < 10; i++) begin
            din = 20'h00012 + 20'(i); din_valid = 1'b1; qout_ready = 1'b1;
            checks++; if (qout !== 20'h00010 + 20'(i)) begin errors++; $display("FAIL b2b_qout got %h exp %h", qout, 20'h00010 + 20'(i)); end
            step();
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", count); end
        end
        din_valid = 1'b0;
        checks++; if (qout !== 20'h0001A) begin errors++; $display("FAIL b2b_tail0 got %h exp 0001a", qout); end
        step();
        checks++; if (qout !== 20'h0001B) begin errors++; $display("FAIL b2b_tail1 got %h exp 0001b", qout); end
        step();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b exp 1", empty); end
        qout_ready = 1'b0;
    endtask

    task automatic test_empty_push_pop();
        din = 20'hABCDE; din_valid = 1'b1; qout_ready = 1'b1;
        checks++; if (qout_valid !== 1'b0) begin errors++; $display("FAIL epp_pre_valid got %b exp 0", qout_valid); end
        step();
        din_valid = 1'b0;
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL epp_count got %0d exp 1", count); end
        checks++; if (qout !== 20'hABCDE) begin errors++; $display("FAIL epp_qout got %h exp abcde", qout); end
        checks++; if (qout_valid !== 1'b1) begin errors++; $display("FAIL epp_valid got %b exp 1", qout_valid); end
        step();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL epp_popped got %b exp 1", empty); end
        qout_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        qout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din = 20'h00030 + 20'(i); din_valid = 1'b1; step();
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL rmid_prefill got %0d exp 3", count); end
        rst_in = 1'b1; din = 20'h00033; din_valid = 1'b1; qout_ready = 1'b1;
        step();
        rst_in = 1'b0; din_valid = 1'b0; qout_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty got %b exp 1", empty); end
        checks++; if (qout !== 20'h0) begin errors++; $display("FAIL rmid_qout got %h exp 00000", qout); end
        checks++; if (qout_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", qout_valid); end
        step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_discard got %0d exp 0", count); end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] q[$];
        logic             hold;
        logic             exp_push;
        logic             exp_pop;
        hold = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (!hold) begin
                din_valid = ($urandom_range(0, 3) != 0);
                din       = 20'($urandom);
            end
            qout_ready = ($urandom_range(0, 1) != 0);
            #1;
            checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", c, count, q.size()); end
            checks++; if (qout_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, qout_valid, q.size() != 0); end
            checks++; if (din_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, din_ready, q.size() < DEPTH); end
            if (q.size() != 0) begin
                checks++; if (qout !== q[0]) begin errors++; $display("FAIL rnd_qout cyc %0d got %h exp %h", c, qout, q[0]); end
            end else begin
                checks++; if (qout !== 20'h0) begin errors++; $display("FAIL rnd_qout_empty cyc %0d got %h exp 00000", c, qout); end
            end
            exp_push = din_valid && (q.size() < DEPTH);
            exp_pop  = qout_ready && (q.size() != 0);
            hold     = din_valid && (q.size() == DEPTH);
            step();
            if (exp_pop)  void'(q.pop_front());
            if (exp_push) q.push_back(din);
        end
        din_valid = 1'b0; qout_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_empty_push_pop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
